// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array sequencing controller.
package systolic_pkg;

  localparam int unsigned SC_N     = 4;
  localparam int unsigned SC_K_MAX = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    RESULT,
    DONE
  } sc_state_e;

  // Skewed feed length: last PE (N-1,N-1) sees its final operands at t = k + 2N - 3.
  function automatic int unsigned feed_len(input int unsigned k, input int unsigned n = SC_N);
    return k + 2 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Command, operand-sequencing and result handshake bundle of systolic_ctrl.
interface systolic_ctrl_if
  import systolic_pkg::*;
#(
  parameter int unsigned N     = SC_N,
  parameter int unsigned K_MAX = SC_K_MAX
);
  localparam int unsigned KW  = $clog2(K_MAX + 1);
  localparam int unsigned KIW = $clog2(K_MAX);
  localparam int unsigned RW  = $clog2(N);

  logic              start;
  logic [KW-1:0]     k_len;
  logic              busy;
  logic              done;
  logic              pe_clr;
  logic              pe_en;
  logic [N*KIW-1:0]  a_k;
  logic [N-1:0]      a_vld;
  logic [N*KIW-1:0]  b_k;
  logic [N-1:0]      b_vld;
  logic [RW-1:0]     res_row;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       perf_cycles;

  modport master (
    output start, k_len, res_ready,
    input  busy, done, pe_clr, pe_en, a_k, a_vld, b_k, b_vld,
           res_row, res_valid, perf_cycles
  );

  modport slave (
    input  start, k_len, res_ready,
    output busy, done, pe_clr, pe_en, a_k, a_vld, b_k, b_vld,
           res_row, res_valid, perf_cycles
  );

endinterface

// File: rtl/systolic_ctrl_skew_gen.sv
// Maps feed time t and inner dimension to N skewed lane indices/valids (lane i lags by i).
module skew_gen
  import systolic_pkg::*;
#(
  parameter int unsigned N     = SC_N,
  parameter int unsigned K_MAX = SC_K_MAX,
  localparam int unsigned KW   = $clog2(K_MAX + 1),
  localparam int unsigned KIW  = $clog2(K_MAX),
  localparam int unsigned TW   = $clog2(K_MAX + 2 * N)
) (
  input  logic             en,
  input  logic [TW-1:0]    t,
  input  logic [KW-1:0]    k_eff,
  output logic [N-1:0]     vld_c,
  output logic [N*KIW-1:0] k_c
);

  localparam int unsigned CW = (TW > KW) ? TW : KW;

  logic [TW-1:0] diff;

  // Guard t >= i before subtracting so the unsigned difference never wraps.
  always_comb begin
    vld_c = '0;
    k_c   = '0;
    diff  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (en && (t >= TW'(i))) begin
        diff = t - TW'(i);
        if (CW'(diff) < CW'(k_eff)) begin
          vld_c[i]           = 1'b1;
          k_c[i*KIW +: KIW]  = KIW'(diff);
        end
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencing controller for an NxN output-stationary systolic MAC array.
// Optional busy-cycle counter enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned N     = SC_N,
  parameter int unsigned K_MAX = SC_K_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  systolic_ctrl_if.slave  bus
);

  localparam int unsigned KW  = $clog2(K_MAX + 1);
  localparam int unsigned KIW = $clog2(K_MAX);
  localparam int unsigned RW  = $clog2(N);
  localparam int unsigned TW  = $clog2(K_MAX + 2 * N);

  sc_state_e        state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [RW-1:0]    r_q, r_d;
  logic [KW-1:0]    keff_q, keff_d;
  logic [TW-1:0]    t_last;
  logic [N-1:0]     a_vld_c, b_vld_c;
  logic [N*KIW-1:0] a_k_c, b_k_c;

  assign t_last = TW'(feed_len(32'(keff_q), N) - 32'd1);

  // Next state and counters.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    r_d     = r_q;
    keff_d  = keff_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          keff_d  = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
          t_d     = '0;
          r_d     = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        t_d     = '0;
        state_d = (keff_q == '0) ? RESULT : FEED;
      end
      FEED: begin
        if (t_q == t_last) begin
          t_d     = '0;
          state_d = RESULT;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          if (r_q == RW'(N - 1)) state_d = DONE;
          else                   r_d     = r_q + RW'(1);
        end
      end
      DONE: begin
        r_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Both operand skews share one schedule; decoded from next state so outputs register cleanly.
  skew_gen #(.N(N), .K_MAX(K_MAX)) u_skew_a (
    .en    (state_d == FEED),
    .t     (t_d),
    .k_eff (keff_d),
    .vld_c (a_vld_c),
    .k_c   (a_k_c)
  );

  skew_gen #(.N(N), .K_MAX(K_MAX)) u_skew_b (
    .en    (state_d == FEED),
    .t     (t_d),
    .k_eff (keff_d),
    .vld_c (b_vld_c),
    .k_c   (b_k_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      t_q           <= '0;
      r_q           <= '0;
      keff_q        <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pe_clr    <= 1'b0;
      bus.pe_en     <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_row   <= '0;
      bus.a_vld     <= '0;
      bus.a_k       <= '0;
      bus.b_vld     <= '0;
      bus.b_k       <= '0;
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      r_q           <= r_d;
      keff_q        <= keff_d;
      bus.busy      <= (state_d != IDLE);
      bus.done      <= (state_d == DONE);
      bus.pe_clr    <= (state_d == CLEAR);
      bus.pe_en     <= (state_d == FEED);
      bus.res_valid <= (state_d == RESULT);
      bus.res_row   <= (state_d == RESULT) ? r_d : '0;
      bus.a_vld     <= a_vld_c;
      bus.a_k       <= a_k_c;
      bus.b_vld     <= b_vld_c;
      bus.b_k       <= b_k_c;
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] cnt_q, cnt_d, perf_q, perf_d;

  // perf_d includes the DONE cycle itself, so the reported figure equals total busy cycles.
  always_comb begin
    cnt_d  = cnt_q;
    perf_d = perf_q;
    if (state_q == IDLE) begin
      if (bus.start) cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
    if (state_d == DONE) perf_d = (cnt_d == '1) ? cnt_d : cnt_d + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      perf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      perf_q <= perf_d;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: directed scenarios plus randomized commands.
module tb_systolic_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned K_MAX = 16;
  localparam int unsigned KW    = $clog2(K_MAX + 1);
  localparam int unsigned KIW   = $clog2(K_MAX);
  localparam int unsigned RW    = $clog2(N);

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  systolic_ctrl_if #(.N(N), .K_MAX(K_MAX)) bus ();

  systolic_ctrl #(.N(N), .K_MAX(K_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_perf(input int busy_cycles);
`ifdef SYSTOLIC_CTRL_PERF_EN
    return 32'(busy_cycles);
`else
    return (busy_cycles > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // Timeline derived from the command: CLEAR at 1, FEED 2..fe+1, RESULT rows (with stall), DONE.
  task automatic run_cmd(input int kl, input int s_row, input int s_cyc,
                         input bit start_mid, input int abort_c);
    int k, fe, done_c, t, j, row;
    logic [N-1:0]     ev;
    logic [N*KIW-1:0] ek;
    logic [4:0]       ectl, actl;
    k      = (kl > int'(K_MAX)) ? int'(K_MAX) : kl;
    fe     = (k == 0) ? 0 : k + 2 * int'(N) - 2;
    done_c = fe + 2 + int'(N) + s_cyc;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.k_len     = KW'(kl);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= done_c + 2; c++) begin
      j   = c - (fe + 2);
      row = (j < s_row) ? j : ((j < s_row + s_cyc) ? s_row : j - s_cyc);
      bus.res_ready = !(j >= 0 && row == s_row && (j - s_row) < s_cyc);
      bus.start     = start_mid && (c >= 2) && (c <= done_c);
      @(negedge clk);
      t  = c - 2;
      ev = '0;
      ek = '0;
      for (int i = 0; i < int'(N); i++) begin
        if (c >= 2 && c <= fe + 1 && t >= i && (t - i) < k) begin
          ev[i]              = 1'b1;
          ek[i*KIW +: KIW]   = KIW'(t - i);
        end
      end
      ectl = {(c <= done_c), (c == done_c), (c == 1), (c >= 2 && c <= fe + 1),
              (c >= fe + 2 && c < done_c)};
      actl = {bus.busy, bus.done, bus.pe_clr, bus.pe_en, bus.res_valid};
      n_chk++;
      if (actl !== ectl) begin
        n_fail++;
        $display("FAIL ctrl k=%0d c=%0d {busy,done,clr,en,rv} got %b exp %b", kl, c, actl, ectl);
      end
      n_chk++;
      if ({bus.a_vld, bus.a_k} !== {ev, ek}) begin
        n_fail++;
        $display("FAIL a_lanes k=%0d c=%0d got vld=%b k=%h exp vld=%b k=%h",
                 kl, c, bus.a_vld, bus.a_k, ev, ek);
      end
      n_chk++;
      if ({bus.b_vld, bus.b_k} !== {ev, ek}) begin
        n_fail++;
        $display("FAIL b_lanes k=%0d c=%0d got vld=%b k=%h exp vld=%b k=%h",
                 kl, c, bus.b_vld, bus.b_k, ev, ek);
      end
      if (c >= fe + 2 && c < done_c) begin
        n_chk++;
        if (bus.res_row !== RW'(row)) begin
          n_fail++;
          $display("FAIL res_row k=%0d c=%0d got %0d exp %0d", kl, c, bus.res_row, row);
        end
      end
      if (c == done_c + 1) begin
        n_chk++;
        if (bus.perf_cycles !== exp_perf(done_c)) begin
          n_fail++;
          $display("FAIL perf k=%0d got %0d exp %0d", kl, bus.perf_cycles, exp_perf(done_c));
        end
      end
      if (c == abort_c) begin
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.busy, bus.done, bus.pe_clr, bus.pe_en, bus.res_valid, bus.a_vld, bus.b_vld,
             bus.a_k, bus.b_k, bus.res_row, bus.perf_cycles} !== '0) begin
          n_fail++;
          $display("FAIL async_reset c=%0d got busy=%b en=%b a_vld=%b a_k=%h perf=%0d exp all 0",
                   c, bus.busy, bus.pe_en, bus.a_vld, bus.a_k, bus.perf_cycles);
        end
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    bus.start     = 1'b0;
    bus.res_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.busy, bus.done, bus.pe_clr, bus.pe_en, bus.res_valid, bus.a_vld, bus.b_vld,
         bus.a_k, bus.b_k, bus.res_row, bus.perf_cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b done=%b clr=%b en=%b rv=%b exp all 0",
               bus.busy, bus.done, bus.pe_clr, bus.pe_en, bus.res_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.busy, bus.pe_clr, bus.pe_en} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_hold c=%0d got busy=%b clr=%b en=%b exp 0", c, bus.busy, bus.pe_clr, bus.pe_en);
      end
    end
  endtask

  task automatic test_basic();
    run_cmd(4, 0, 0, 1'b0, 0);
  endtask

  task automatic test_k_zero();
    run_cmd(0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_k_saturate();
    run_cmd(20, 0, 0, 1'b0, 0);
    run_cmd(16, 3, 1, 1'b0, 0);
  endtask

  task automatic test_stall_ignore_start();
    run_cmd(4, 2, 3, 1'b1, 0);
  endtask

  task automatic test_reset_mid_feed();
    run_cmd(4, 0, 0, 1'b0, 7);
    run_cmd(5, 1, 2, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_cmd(int'($urandom_range(0, 20)), int'($urandom_range(0, N - 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(1, 0, 0, 1'b0, 0);
    run_cmd(2, 3, 2, 1'b1, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_k_zero();
    test_k_saturate();
    test_stall_ignore_start();
    test_reset_mid_feed();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
